mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data-memory bus alongside data_memory and acts as a store/load responder. The CPU writes bytes into a small TX FIFO, and a serialiser shifts them out on tx as 8N1 frames, LSB first. Status and divisor registers are readable, so firmware can poll before writing. The same ports as data_memory let the bench or top level OR this block's data_out with memory read data.

---
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Optional parity stage enabled by defining UART_PARITY_EN.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          overflow;
    logic [15:0]   clkdiv;
    logic [15:0]   div_eff, div_sh, baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift, head;
    logic          sel, full, empty, busy, push_req, push, pop, baud_done;
    logic [1:0]    reg_idx;
    logic [31:0]   status;
    logic          parity_adv;
    logic          unused_ok;

`ifdef UART_PARITY_EN
    logic          par_bit;
    assign parity_adv = 1'b1;
`else
    assign parity_adv = 1'b0;
`endif

    // Size/sign and sub-word address bits are irrelevant: only byte lane 0 is used.
    assign unused_ok = ^{mem_ctrl, data_in[31:16], addr[1:0]};

    assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx  = addr[3:2];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = wr_en && sel && (reg_idx == 2'd0);
    // Full is judged on pre-edge pointers, so a push racing a pop of a full FIFO is dropped.
    assign push     = push_req && !full;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign div_eff  = (clkdiv == 16'd0) ? 16'd1 : clkdiv;
    assign busy     = (state != S_IDLE);
    assign irq      = empty && (state == S_IDLE);
    assign status   = {27'd0, parity_adv, overflow, busy, empty, full};
    assign baud_done = (baud_cnt == div_sh - 16'd1);

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (reg_idx)
                2'd1:    data_out = status;
                2'd2:    data_out = {16'd0, clkdiv};
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            clkdiv   <= DEFAULT_DIV;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (wr_en && sel && reg_idx == 2'd1 && data_in[3]) begin
                overflow <= 1'b0;
            end
            if (wr_en && sel && reg_idx == 2'd2) begin
                clkdiv <= data_in[15:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (baud_done) state_n = S_DATA;
            end
            S_DATA: begin
                tx = shift[0];
                if (baud_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx = par_bit;
                if (baud_done) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                // Popping on the last stop cycle chains frames without an idle gap.
                if (baud_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            div_sh   <= 16'd1;
`ifdef UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (pop) begin
                shift    <= head;
                div_sh   <= div_eff;
                baud_cnt <= '0;
                bit_cnt  <= '0;
`ifdef UART_PARITY_EN
                par_bit  <= ^head;
`endif
            end else if (state != S_IDLE) begin
                if (baud_done) begin
                    baud_cnt <= '0;
                    if (state == S_DATA) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_PARITY_EN
    localparam int          FL  = 11;
    localparam logic [31:0] PB  = 32'h10;
    localparam logic [10:0] F55 = 11'b10010101010;
    localparam logic [10:0] FA5 = 11'b10101001010;
    localparam logic [10:0] F3C = 11'b10001111000;
    localparam logic [10:0] FFF = 11'b10111111110;
    localparam logic [10:0] F07 = 11'b11000001110;
`else
    localparam int          FL  = 10;
    localparam logic [31:0] PB  = 32'h0;
    localparam logic [10:0] F55 = 11'b01010101010;
    localparam logic [10:0] FA5 = 11'b01101001010;
    localparam logic [10:0] F3C = 11'b01001111000;
    localparam logic [10:0] FFF = 11'b01111111110;
    localparam logic [10:0] F07 = 11'b01000001110;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .mem_ctrl (mem_ctrl),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        data_in = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    task automatic check_frame(input string tag, input logic [10:0] fr, input int div);
        for (int b = 0; b < FL; b++) begin
            for (int c = 0; c < div; c++) begin
                tick();
                wr_en = 1'b0;
                addr  = BASE + 32'h4;
                #1;
                chk({tag, "_tx"}, {31'd0, tx}, {31'd0, fr[b]});
                chk({tag, "_busy"}, {31'd0, data_out[2]}, 32'd1);
                chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        mem_ctrl = 3'd0;
        addr     = 32'd0;
        data_in  = 32'd0;
        tick();
        tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        rd("rst_status", BASE + 32'h4, 32'h2 | PB);
        rd("rst_clkdiv", BASE + 32'h8, 32'h10);
        rd("outside", BASE + 32'h24, 32'h0);
        rd("txdata_rd", BASE, 32'h0);
        rd("reserved_rd", BASE + 32'hC, 32'h0);

        // Single frame, div 4
        wr(BASE + 32'h8, 32'h4);
        rd("clkdiv4", BASE + 32'h8, 32'h4);
        wr(BASE, 32'h55);
        chk("pre_pop_tx", {31'd0, tx}, 32'd1);
        check_frame("f55", F55, 4);
        tick();
        chk("f55_irq_end", {31'd0, irq}, 32'd1);
        chk("f55_tx_end", {31'd0, tx}, 32'd1);
        rd("f55_status_end", BASE + 32'h4, 32'h2 | PB);

        // Back-to-back frames, div 2: second push lands on the first pop edge
        wr(BASE + 32'h8, 32'h2);
        wr(BASE, 32'hA5);
        wr_en   = 1'b1;
        addr    = BASE;
        data_in = 32'h3C;
        check_frame("fA5", FA5, 2);
        check_frame("f3C", F3C, 2);
        tick();
        chk("b2b_irq_end", {31'd0, irq}, 32'd1);

        // FIFO fill and overflow with a stalled serialiser
        wr(BASE + 32'h8, 32'd100);
        for (int i = 0; i < 5; i++) wr(BASE, 32'h11 + i);
        rd("fill_status", BASE + 32'h4, 32'h5 | PB);
        wr(BASE, 32'h99);
        rd("ovf_status", BASE + 32'h4, 32'hD | PB);
        wr(BASE + 32'h4, 32'h0);
        rd("ovf_keep", BASE + 32'h4, 32'hD | PB);
        wr(BASE + 32'h4, 32'h8);
        rd("ovf_clear", BASE + 32'h4, 32'h5 | PB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("rst2_status", BASE + 32'h4, 32'h2 | PB);
        rd("rst2_clkdiv", BASE + 32'h8, 32'h10);

        // CLKDIV of zero behaves as one cycle per bit
        wr(BASE + 32'h8, 32'h0);
        rd("clkdiv0", BASE + 32'h8, 32'h0);
        wr(BASE, 32'hFF);
        check_frame("fFF", FFF, 1);
        tick();
        chk("fFF_irq_end", {31'd0, irq}, 32'd1);

        wr(BASE + 32'h8, 32'h2);
        wr(BASE, 32'h07);
        check_frame("f07", F07, 2);
        tick();
        chk("f07_irq_end", {31'd0, irq}, 32'd1);

        // Reset 13 cycles into a div 4 frame with two bytes queued
        wr(BASE + 32'h8, 32'h4);
        wr(BASE, 32'h55);
        wr(BASE, 32'hA5);
        wr(BASE, 32'h3C);
        repeat (11) tick();
        rd("mid_status", BASE + 32'h4, 32'h4 | PB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_irq", {31'd0, irq}, 32'd1);
        rd("mid_rst_status", BASE + 32'h4, 32'h2 | PB);
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("post_rst_tx", {31'd0, tx}, 32'd1);
        end
        rd("post_rst_status", BASE + 32'h4, 32'h2 | PB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
